// File: rtl/gb_stencil_seq.sv
// Gaussian-blur stencil sequencer: stream handshakes, row/col counters, line-buffer write pointer.
// Ports: clk, rst, start, in_tvalid/in_tready, out_tvalid/out_tready/out_tlast,
//   lb_addr, lb_wr_sel, lb_wr_en, win_shift, out_load, busy, frame_done.
// Optional macro GB_PERF_CNT_EN adds stall_cnt (RUN cycles with in_tvalid && !in_tready).
module gb_stencil_seq #(
  parameter int IMG_W = 488,
  parameter int IMG_H = 648,
  parameter int WIN   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_tvalid,
  output logic        in_tready,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic        out_tlast,
  output logic [8:0]  lb_addr,
  output logic [2:0]  lb_wr_sel,
  output logic        lb_wr_en,
  output logic        win_shift,
  output logic        out_load,
  output logic        busy,
  output logic        frame_done
`ifdef GB_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [8:0] X_LAST = 9'(IMG_W - 1);
  localparam logic [9:0] Y_LAST = 10'(IMG_H - 1);
  localparam logic [8:0] X_WIN  = 9'(WIN - 1);
  localparam logic [9:0] Y_WIN  = 10'(WIN - 1);

  logic [1:0] state;
  logic [8:0] x;
  logic [9:0] y;
  logic [2:0] w;
  logic       accept;
  logic       x_end;
  logic       last_px;

  // Hold off input while an unaccepted result is pending.
  assign in_tready  = (state == S_RUN) &&
                      (!out_tvalid || out_tready);
  assign accept     = in_tvalid && in_tready;
  assign x_end      = (x == X_LAST);
  assign last_px    = x_end && (y == Y_LAST);

  assign lb_addr    = x;
  assign lb_wr_sel  = w;
  assign lb_wr_en   = accept;
  assign win_shift  = accept;
  assign out_load   = accept && (x >= X_WIN) &&
                      (y >= Y_WIN);
  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      w          <= '0;
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            x     <= '0;
            y     <= '0;
            w     <= '0;
          end
        end
        S_RUN: begin
          if (accept && last_px) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (out_tvalid && out_tready && out_tlast)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // accept only occurs in RUN, so this never
      // collides with the clear on start.
      if (accept) begin
        if (x_end) begin
          x <= '0;
          y <= last_px ? 10'd0 : y + 10'd1;
          // oldest line buffer rotates once per row
          w <= w + 3'd1;
        end else begin
          x <= x + 9'd1;
        end
      end

      // A load in the same cycle as a drain keeps
      // the output valid with the new result.
      if (out_load) begin
        out_tvalid <= 1'b1;
        out_tlast  <= last_px;
      end else if (out_tready) begin
        out_tvalid <= 1'b0;
        out_tlast  <= 1'b0;
      end
    end
  end

`ifdef GB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      stall_cnt <= '0;
    end else if (state == S_RUN && in_tvalid &&
                 !in_tready &&
                 stall_cnt != 32'hFFFF_FFFF) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gb_stencil_seq.sv
// Directed bench for gb_stencil_seq at IMG_W=12, IMG_H=10, WIN=9.
// Ports all connected; stall_cnt only when GB_PERF_CNT_EN is defined.
module tb_gb_stencil_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_tvalid;
  logic       in_tready;
  logic       out_tvalid;
  logic       out_tready;
  logic       out_tlast;
  logic [8:0] lb_addr;
  logic [2:0] lb_wr_sel;
  logic       lb_wr_en;
  logic       win_shift;
  logic       out_load;
  logic       busy;
  logic       frame_done;
`ifdef GB_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gb_stencil_seq #(
    .IMG_W(12),
    .IMG_H(10),
    .WIN  (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tlast (out_tlast),
    .lb_addr   (lb_addr),
    .lb_wr_sel (lb_wr_sel),
    .lb_wr_en  (lb_wr_en),
    .win_shift (win_shift),
    .out_load  (out_load),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef GB_PERF_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // Stimulus only: pulse start with pixels already offered.
  task automatic start_frame();
    @(negedge clk);
    start = 1'b1;
    in_tvalid = 1'b1;
    out_tready = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    in_tvalid = 1'b1;
    out_tready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({out_tvalid, out_tlast, frame_done, busy,
         lb_wr_en, win_shift, out_load, in_tready}
        !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags tv=%b tl=%b fd=%b bz=%b we=%b sh=%b ld=%b rdy=%b required all 0",
               out_tvalid, out_tlast, frame_done, busy,
               lb_wr_en, win_shift, out_load, in_tready);
    end
    checks++;
    if (lb_addr !== 9'd0 || lb_wr_sel !== 3'd0) begin
      failures++;
      $display("FAIL reset_ptrs addr=%0d sel=%0d required 0 0",
               lb_addr, lb_wr_sel);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_full_frame();
    int acc = 0;
    int outs = 0;
    int tl = 0;
    int hs_cyc = -1;
    int fd_cyc = -1;
    int fd_n = 0;
    int first_load = -1;
    bit done = 0;
    bit exp_ld;
    start_frame();
    checks++;
    if (in_tready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL ff_start_cycle rdy=%b busy=%b required 0 0",
               in_tready, busy);
    end
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (in_tvalid && in_tready) begin
        exp_ld = (acc % 12 >= 8) && (acc / 12 >= 8);
        checks++;
        if (lb_addr !== 9'(acc % 12) ||
            lb_wr_sel !== 3'((acc / 12) % 8) ||
            lb_wr_en !== 1'b1 || win_shift !== 1'b1 ||
            out_load !== exp_ld) begin
          failures++;
          $display("FAIL ff_beat%0d addr=%0d sel=%0d we=%b sh=%b ld=%b required %0d %0d 1 1 %b",
                   acc, lb_addr, lb_wr_sel, lb_wr_en,
                   win_shift, out_load, acc % 12,
                   (acc / 12) % 8, exp_ld);
        end
        if (out_load && first_load < 0) first_load = acc;
        acc++;
      end
      if (out_tvalid && out_tready) begin
        outs++;
        hs_cyc = cyc;
        if (out_tlast) tl++;
        checks++;
        if (out_tlast !== (outs == 8)) begin
          failures++;
          $display("FAIL ff_tlast out%0d tlast=%b required %b",
                   outs, out_tlast, outs == 8);
        end
      end
      if (frame_done) begin
        fd_cyc = cyc;
        fd_n++;
      end
      if (!busy) done = 1;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL ff_timeout busy=%b required 0", busy);
    end
    checks++;
    if (acc != 120 || outs != 8 || tl != 1) begin
      failures++;
      $display("FAIL ff_counts acc=%0d outs=%0d tlast=%0d required 120 8 1",
               acc, outs, tl);
    end
    checks++;
    if (first_load != 104) begin
      failures++;
      $display("FAIL ff_first_load beat=%0d required 104",
               first_load);
    end
    checks++;
    if (fd_n != 1 || fd_cyc != hs_cyc + 1) begin
      failures++;
      $display("FAIL ff_frame_done n=%0d at=%0d required 1 at %0d",
               fd_n, fd_cyc, hs_cyc + 1);
    end
  endtask

  task automatic test_backpressure(input int n);
    int acc = 0;
    int outs = 0;
    int tl = 0;
    int st = 0;
    bit stalling;
    bit resumed = 0;
    bit done = 0;
    start_frame();
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_tvalid && outs == 0 && st < n) begin
        out_tready = 1'b0;
        stalling = 1;
        st++;
      end else begin
        out_tready = 1'b1;
        stalling = 0;
      end
      #1;
      if (stalling) begin
        checks++;
        if (in_tready !== 1'b0 || lb_wr_en !== 1'b0 ||
            out_tvalid !== 1'b1 || out_tlast !== 1'b0 ||
            lb_addr !== 9'd9 || lb_wr_sel !== 3'd0) begin
          failures++;
          $display("FAIL bp%0d_hold rdy=%b we=%b tv=%b tl=%b addr=%0d sel=%0d required 0 0 1 0 9 0",
                   n, in_tready, lb_wr_en, out_tvalid,
                   out_tlast, lb_addr, lb_wr_sel);
        end
      end else if (st == n && !resumed) begin
        resumed = 1;
        checks++;
        if (in_tready !== 1'b1 || out_tvalid !== 1'b1) begin
          failures++;
          $display("FAIL bp%0d_resume rdy=%b tv=%b required 1 1",
                   n, in_tready, out_tvalid);
        end
`ifdef GB_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'(n)) begin
          failures++;
          $display("FAIL bp%0d_stall_cnt got=%0d required %0d",
                   n, stall_cnt, n);
        end
`endif
      end
      if (in_tvalid && in_tready) begin
        checks++;
        if (lb_addr !== 9'(acc % 12) ||
            lb_wr_sel !== 3'((acc / 12) % 8)) begin
          failures++;
          $display("FAIL bp%0d_beat%0d addr=%0d sel=%0d required %0d %0d",
                   n, acc, lb_addr, lb_wr_sel, acc % 12,
                   (acc / 12) % 8);
        end
        acc++;
      end
      if (out_tvalid && out_tready) begin
        outs++;
        if (out_tlast) tl++;
      end
      if (!busy) done = 1;
    end
    checks++;
    if (!done || acc != 120 || outs != 8 || tl != 1 ||
        st != n) begin
      failures++;
      $display("FAIL bp%0d_counts done=%b acc=%0d outs=%0d tlast=%0d stalls=%0d required 1 120 8 1 %0d",
               n, done, acc, outs, tl, st, n);
    end
`ifdef GB_PERF_CNT_EN
    checks++;
    if (stall_cnt !== 32'(n)) begin
      failures++;
      $display("FAIL bp%0d_stall_end got=%0d required %0d",
               n, stall_cnt, n);
    end
`endif
  endtask

  task automatic test_start_ignored();
    int acc = 0;
    int outs = 0;
    int tl = 0;
    int last_out = 0;
    bit pulsed = 0;
    bit done = 0;
    start_frame();
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      start = (acc == 48 && !pulsed);
      if (start) pulsed = 1;
      #1;
      if (in_tvalid && in_tready) begin
        checks++;
        if (lb_addr !== 9'(acc % 12) ||
            lb_wr_sel !== 3'((acc / 12) % 8)) begin
          failures++;
          $display("FAIL si_beat%0d addr=%0d sel=%0d required %0d %0d",
                   acc, lb_addr, lb_wr_sel, acc % 12,
                   (acc / 12) % 8);
        end
        acc++;
      end
      if (out_tvalid && out_tready) begin
        outs++;
        if (out_tlast) begin
          tl++;
          last_out = outs;
        end
      end
      if (!busy) done = 1;
    end
    start = 1'b0;
    checks++;
    if (!done || !pulsed || acc != 120 || outs != 8 ||
        tl != 1 || last_out != 8) begin
      failures++;
      $display("FAIL si_counts done=%b pulsed=%b acc=%0d outs=%0d tlast=%0d at=%0d required 1 1 120 8 1 8",
               done, pulsed, acc, outs, tl, last_out);
    end
  endtask

  task automatic test_mid_reset();
    int acc = 0;
    int outs = 0;
    int tl = 0;
    bit hit = 0;
    bit done = 0;
    start_frame();
    for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (acc == 113) hit = 1;
      else if (in_tvalid && in_tready) acc++;
    end
    checks++;
    if (!hit || lb_addr !== 9'd5 || lb_wr_sel !== 3'd1) begin
      failures++;
      $display("FAIL mr_position hit=%b addr=%0d sel=%0d required 1 5 1",
               hit, lb_addr, lb_wr_sel);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_tvalid !== 1'b0 ||
        out_tlast !== 1'b0 || in_tready !== 1'b0 ||
        frame_done !== 1'b0 || lb_addr !== 9'd0 ||
        lb_wr_sel !== 3'd0) begin
      failures++;
      $display("FAIL mr_after bz=%b tv=%b tl=%b rdy=%b fd=%b addr=%0d sel=%0d required 0 0 0 0 0 0 0",
               busy, out_tvalid, out_tlast, in_tready,
               frame_done, lb_addr, lb_wr_sel);
    end
    acc = 0;
    start_frame();
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (in_tvalid && in_tready) begin
        checks++;
        if (lb_addr !== 9'(acc % 12) ||
            lb_wr_sel !== 3'((acc / 12) % 8)) begin
          failures++;
          $display("FAIL mr_beat%0d addr=%0d sel=%0d required %0d %0d",
                   acc, lb_addr, lb_wr_sel, acc % 12,
                   (acc / 12) % 8);
        end
        acc++;
      end
      if (out_tvalid && out_tready) begin
        outs++;
        if (out_tlast) tl++;
      end
      if (!busy) done = 1;
    end
    checks++;
    if (!done || acc != 120 || outs != 8 || tl != 1) begin
      failures++;
      $display("FAIL mr_counts done=%b acc=%0d outs=%0d tlast=%0d required 1 120 8 1",
               done, acc, outs, tl);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    in_tvalid = 1'b0;
    out_tready = 1'b0;
    test_reset();
    test_full_frame();
    test_backpressure(5);
`ifdef GB_PERF_CNT_EN
    test_backpressure(7);
`endif
    test_start_ignored();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
